// File: rtl/lcd_seq_ctrl.sv
// Power-on init and single-byte write sequencer for an HD44780-style 8-bit LCD bus.
// Optional LCD_TWO_LINE_EN selects the 2-line function-set byte during init.
module lcd_seq_ctrl #(
  parameter int SETUP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_250ns,
  input  logic       flag_42us,
  input  logic       flag_100us,
  input  logic       flag_1640us,
  input  logic       flag_4100us,
  input  logic       flag_15000us,
  output logic       flag_rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  typedef enum logic [2:0] {S_PWR, S_SETUP, S_EHI, S_EXEC, S_IDLE} state_t;

  localparam logic [1:0] W_42   = 2'd0;
  localparam logic [1:0] W_100  = 2'd1;
  localparam logic [1:0] W_1640 = 2'd2;
  localparam logic [1:0] W_4100 = 2'd3;
  localparam int CNT_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

`ifdef LCD_TWO_LINE_EN
  localparam logic [7:0] FUNC_SET = 8'h38;
`else
  localparam logic [7:0] FUNC_SET = 8'h30;
`endif

  function automatic logic [7:0] init_byte(input logic [2:0] step);
    case (step)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = FUNC_SET;
      3'd4:             init_byte = 8'h0C;
      3'd5:             init_byte = 8'h01;
      3'd6:             init_byte = 8'h06;
      default:          init_byte = 8'h00;
    endcase
  endfunction

  function automatic logic [1:0] init_wait(input logic [2:0] step);
    case (step)
      3'd0:       init_wait = W_4100;
      3'd1, 3'd2: init_wait = W_100;
      3'd5:       init_wait = W_1640;
      default:    init_wait = W_42;
    endcase
  endfunction

  // Clear display / return home are the only slow client instructions.
  function automatic logic [1:0] client_wait(input logic rs, input logic [7:0] d);
    if (!rs && (d[7:2] == 6'd0) && (d != 8'h00)) client_wait = W_1640;
    else                                         client_wait = W_42;
  endfunction

  state_t           state_q;
  logic [2:0]       step_q;
  logic             init_q;
  logic [1:0]       wait_q;
  logic [CNT_W-1:0] cnt_q;
  logic             flag_rst_q;
  logic             lcd_e_q;
  logic             lcd_rs_q;
  logic [7:0]       lcd_data_q;
  logic             wr_ready_q;
  logic             init_done_q;
  logic             exec_hit_d;
  logic [2:0]       step_nxt_d;

  always_comb begin
    exec_hit_d = 1'b0;
    case (wait_q)
      W_42:    exec_hit_d = flag_42us;
      W_100:   exec_hit_d = flag_100us;
      W_1640:  exec_hit_d = flag_1640us;
      W_4100:  exec_hit_d = flag_4100us;
      default: exec_hit_d = 1'b0;
    endcase
  end

  assign step_nxt_d = step_q + 3'd1;

  // flag_rst_q is high exactly in the first cycle of a timed state, so it doubles
  // as the "flags may still be stale" marker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PWR;
      step_q      <= 3'd0;
      init_q      <= 1'b1;
      wait_q      <= W_4100;
      cnt_q       <= '0;
      flag_rst_q  <= 1'b1;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 8'h00;
      wr_ready_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      flag_rst_q <= 1'b0;
      case (state_q)
        S_PWR: begin
          if (!flag_rst_q && flag_15000us) begin
            state_q    <= S_SETUP;
            step_q     <= 3'd0;
            init_q     <= 1'b1;
            cnt_q      <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_data_q <= init_byte(3'd0);
            wait_q     <= init_wait(3'd0);
          end
        end
        S_SETUP: begin
          if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
            state_q    <= S_EHI;
            lcd_e_q    <= 1'b1;
            flag_rst_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_EHI: begin
          if (!flag_rst_q && flag_250ns) begin
            state_q    <= S_EXEC;
            lcd_e_q    <= 1'b0;
            flag_rst_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!flag_rst_q && exec_hit_d) begin
            if (init_q && (step_q != 3'd6)) begin
              state_q    <= S_SETUP;
              step_q     <= step_nxt_d;
              cnt_q      <= '0;
              lcd_data_q <= init_byte(step_nxt_d);
              wait_q     <= init_wait(step_nxt_d);
            end else begin
              state_q     <= S_IDLE;
              init_q      <= 1'b0;
              init_done_q <= 1'b1;
              wr_ready_q  <= 1'b1;
            end
          end
        end
        S_IDLE: begin
          if (wr_valid && wr_ready_q) begin
            state_q    <= S_SETUP;
            cnt_q      <= '0;
            wr_ready_q <= 1'b0;
            lcd_rs_q   <= wr_rs;
            lcd_data_q <= wr_data;
            wait_q     <= client_wait(wr_rs, wr_data);
          end
        end
        default: state_q <= S_PWR;
      endcase
    end
  end

  assign flag_rst  = flag_rst_q;
  assign wr_ready  = wr_ready_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Bench for lcd_seq_ctrl with a scaled-down behavioural flag timer.
// Timer thresholds are shortened so the whole init sequence runs in a few thousand cycles.
module tb_lcd_seq_ctrl;

  localparam int SETUP_CYC = 2;
  localparam int T250   = 13;
  localparam int T42    = 40;
  localparam int T100   = 60;
  localparam int T1640  = 200;
  localparam int T4100  = 300;
  localparam int T15000 = 500;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_250ns, flag_42us, flag_100us, flag_1640us, flag_4100us, flag_15000us;
  logic       flag_rst;
  logic       wr_valid;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;

  int n_chk  = 0;
  int n_fail = 0;
  int tcnt   = 0;

  always #5 clk = ~clk;

  // Free-running elapsed-time counter; flags stay high (stale) until the next flag_rst.
  always @(posedge clk) begin
    if (flag_rst) tcnt <= 0;
    else if (tcnt < 1000000) tcnt <= tcnt + 1;
  end

  assign flag_250ns   = (tcnt >= T250);
  assign flag_42us    = (tcnt >= T42);
  assign flag_100us   = (tcnt >= T100);
  assign flag_1640us  = (tcnt >= T1640);
  assign flag_4100us  = (tcnt >= T4100);
  assign flag_15000us = (tcnt >= T15000);

  lcd_seq_ctrl #(.SETUP_CYC(SETUP_CYC)) dut (
    .clk          (clk),
    .rst          (rst),
    .flag_250ns   (flag_250ns),
    .flag_42us    (flag_42us),
    .flag_100us   (flag_100us),
    .flag_1640us  (flag_1640us),
    .flag_4100us  (flag_4100us),
    .flag_15000us (flag_15000us),
    .flag_rst     (flag_rst),
    .wr_valid     (wr_valid),
    .wr_rs        (wr_rs),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .init_done    (init_done),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_e        (lcd_e),
    .lcd_data     (lcd_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // n = number of negedges seen with lcd_e != lvl before the one where it matches.
  task automatic wait_e(input logic lvl, input int budget, output int n);
    n = 0;
    @(negedge clk);
    while (lcd_e !== lvl && n < budget) begin
      n++;
      @(negedge clk);
    end
    if (lcd_e !== lvl) chk("lcd_e_timeout", {31'd0, lcd_e}, {31'd0, lvl});
  endtask

  // sel 0: init_done, sel 1: wr_ready. n = low negedges seen before it is high.
  task automatic wait_hi(input int sel, input int budget, output int n);
    logic v;
    n = 0;
    @(negedge clk);
    v = (sel == 0) ? init_done : wr_ready;
    while (v !== 1'b1 && n < budget) begin
      n++;
      @(negedge clk);
      v = (sel == 0) ? init_done : wr_ready;
    end
    if (v !== 1'b1) chk((sel == 0) ? "init_done_timeout" : "wr_ready_timeout", {31'd0, v}, 32'd1);
  endtask

  // Returns at the negedge where lcd_e is first seen low again.
  task automatic pulse(output logic [7:0] d, output logic rs, output int low_n, output int hi_n);
    wait_e(1'b1, 5000, low_n);
    d  = lcd_data;
    rs = lcd_rs;
    chk("flag_rst_at_e_rise", {31'd0, flag_rst}, 32'd1);
    chk("lcd_rw_zero", {31'd0, lcd_rw}, 32'd0);
    wait_e(1'b0, 200, hi_n);
    hi_n = hi_n + 1;
    chk("bus_hold_data", {24'd0, lcd_data}, {24'd0, d});
    chk("bus_hold_rs", {31'd0, lcd_rs}, {31'd0, rs});
  endtask

  task automatic in_range(input string tag, input int v, input int lo, input int hi);
    chk(tag, v, (v < lo) ? lo : (v > hi) ? hi : v);
  endtask

  task automatic do_write(input logic rs, input logic [7:0] d, input int th, input string name);
    logic [7:0] pd;
    logic       prs;
    int lo, hi, n;
    @(negedge clk);
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    wait_hi(1, 1000, n);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_rs    = ~rs;
    wr_data  = ~d;
    pulse(pd, prs, lo, hi);
    chk({name, "_accept_to_e"}, lo, SETUP_CYC);
    chk({name, "_data"}, {24'd0, pd}, {24'd0, d});
    chk({name, "_rs"}, {31'd0, prs}, {31'd0, rs});
    in_range({name, "_e_high"}, hi, 14, 20);
    chk({name, "_ready_low_in_exec"}, {31'd0, wr_ready}, 32'd0);
    wait_hi(1, 2000, n);
    in_range({name, "_ready_return"}, n + 1, th, th + 10);
  endtask

  logic [7:0] exp_init [7];
  int         exp_gap  [6];

  initial begin
    logic [7:0] d;
    logic       rs;
    int lo, hi, n, extra;

    exp_init[0] = 8'h30; exp_init[1] = 8'h30; exp_init[2] = 8'h30;
`ifdef LCD_TWO_LINE_EN
    exp_init[3] = 8'h38;
`else
    exp_init[3] = 8'h30;
`endif
    exp_init[4] = 8'h0C; exp_init[5] = 8'h01; exp_init[6] = 8'h06;
    exp_gap[0] = T4100; exp_gap[1] = T100; exp_gap[2] = T100;
    exp_gap[3] = T42;   exp_gap[4] = T42;  exp_gap[5] = T1640;

    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_rs    = 1'b0;
    wr_data  = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("rst_lcd_rs", {31'd0, lcd_rs}, 32'd0);
    chk("rst_lcd_rw", {31'd0, lcd_rw}, 32'd0);
    chk("rst_lcd_data", {24'd0, lcd_data}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_flag_rst", {31'd0, flag_rst}, 32'd1);

    // Client asserts a request before init has even started.
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h55;
    rst      = 1'b0;
    fork
      begin
        pulse(d, rs, lo, hi);
        in_range("pwr_wait", lo, T15000, T15000 + 10);
        chk("init0_data", {24'd0, d}, {24'd0, exp_init[0]});
        chk("init0_rs", {31'd0, rs}, 32'd0);
        in_range("init0_e_high", hi, 14, 20);
        for (int i = 1; i < 7; i++) begin
          pulse(d, rs, lo, hi);
          chk($sformatf("init%0d_data", i), {24'd0, d}, {24'd0, exp_init[i]});
          chk($sformatf("init%0d_rs", i), {31'd0, rs}, 32'd0);
          in_range($sformatf("init%0d_gap", i), lo + 1, exp_gap[i-1], exp_gap[i-1] + 10);
        end
        wait_hi(0, 2000, n);
        in_range("init_done_delay", n + 1, T42, T42 + 10);
        pulse(d, rs, lo, hi);
        chk("early_req_data", {24'd0, d}, 32'h55);
        chk("early_req_rs", {31'd0, rs}, 32'd1);
        wait_hi(1, 2000, n);
        extra = 0;
        repeat (30) begin
          @(negedge clk);
          if (lcd_e) extra++;
        end
        chk("early_req_once", extra, 0);
      end
      begin
        wait_hi(1, 20000, n);
        chk("early_req_after_init", {31'd0, init_done}, 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_data  = 8'hFF;
      end
    join

    do_write(1'b1, 8'h41, T42, "data41");
    do_write(1'b0, 8'h01, T1640, "clear01");
    do_write(1'b0, 8'h80, T42, "cmd80");
    do_write(1'b0, 8'h02, T1640, "home02");

    // Reset in the middle of an E pulse.
    @(negedge clk);
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h5A;
    wait_hi(1, 1000, n);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wait_e(1'b1, 100, n);
    repeat (3) @(negedge clk);
    chk("mid_pulse_e_high", {31'd0, lcd_e}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_lcd_e", {31'd0, lcd_e}, 32'd0);
    chk("midrst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("midrst_init_done", {31'd0, init_done}, 32'd0);
    chk("midrst_flag_rst", {31'd0, flag_rst}, 32'd1);
    rst = 1'b0;
    pulse(d, rs, lo, hi);
    in_range("restart_pwr_wait", lo, T15000, T15000 + 10);
    chk("restart_data", {24'd0, d}, 32'h30);
    chk("restart_rs", {31'd0, rs}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lcd_seq_ctrl.md
# lcd_seq_ctrl

Sequencer for the HD44780-compatible 8-bit LCD bus. Sits directly downstream of `flag_controller`: it pulses that block's `flag_rst` to start each timed interval, then consumes the resulting `flag_*` outputs.

- Runs the power-on init sequence, then accepts single command/data bytes from a valid/ready client.
- Generates RS, RW, E and DB[7:0] with the required setup, pulse-width and execution delays.

## Interface
Parameters:
- `SETUP_CYC`, default 2: cycles RS/DB are held stable with E low before E rises (2 × 20 ns = 40 ns at 50 MHz).

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `flag_250ns`, `flag_42us`, `flag_100us`, `flag_1640us`, `flag_4100us`, `flag_15000us` in 1 each: sticky elapsed-time flags from the timer; cleared by `flag_rst`.
- `flag_rst` out 1: one-cycle pulse that clears the timer and restarts its count.
- `wr_valid` in 1: client request.
- `wr_rs` in 1: 0 = command, 1 = data.
- `wr_data` in 8: byte to write.
- `wr_ready` out 1: block can accept a byte.
- `init_done` out 1: init sequence complete; sticky until `rst`.
- `lcd_rs` out 1: LCD register select.
- `lcd_rw` out 1: LCD read/write; constant 0.
- `lcd_e` out 1: LCD enable strobe.
- `lcd_data` out 8: LCD data bus DB[7:0].

## Operation
- **Reset values:** `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=0x00, `wr_ready`=0, `init_done`=0. `flag_rst`=1 while `rst` is high.
- **States:** PWR, SETUP, EHI, EXEC, IDLE. All outputs are registered.
- **Timed states** are PWR, EHI and EXEC.
  - `flag_rst`=1 in the first cycle of each timed state.
  - Flag inputs are ignored in that first cycle and sampled from the second cycle on.
- **PWR:** entered on `rst` release. Waits for `flag_15000us`, then goes to SETUP with init step 0.
- **SETUP:** drives `lcd_rs`/`lcd_data` with `lcd_e`=0 for `SETUP_CYC` cycles, then goes to EHI.
- **EHI:** `lcd_e`=1 and bus held. Exits on `flag_250ns` to EXEC.
- **EXEC:** `lcd_e`=0 and bus held. Exits on the selected exec flag:
  - During init, go to SETUP with the next step, or to IDLE after step 6.
  - After a client write, go to IDLE.
- **Init bytes (all RS=0) and exec waits:**
  - Step 0: 0x30, 4100 us.
  - Step 1: 0x30, 100 us.
  - Step 2: 0x30, 100 us.
  - Step 3: function set (see Configuration), 42 us.
  - Step 4: 0x0C, 42 us.
  - Step 5: 0x01, 1640 us.
  - Step 6: 0x06, 42 us.
- **IDLE:** `init_done`=1 and `wr_ready`=1.
  - On `wr_valid && wr_ready`: capture `wr_rs`/`wr_data`, drop `wr_ready` next cycle, go to SETUP.
- **Client exec wait:** `flag_1640us` if `wr_rs`=0 and `wr_data[7:2]`=0 and `wr_data`≠0 (clear/home); otherwise `flag_42us`.

## Timing
- Accept to E rise: 1 + `SETUP_CYC` cycles.
- E high time: at least 14 cycles (280 ns), set by the timer's 13-count threshold plus the register stage.
- `wr_ready` is low from the cycle after accept until the cycle after EXEC completes.
- `wr_valid` outside IDLE is ignored. The client must hold it (standard valid/ready).
- Captured byte and RS stay stable on the bus from SETUP through EXEC. Later changes on `wr_*` have no effect.
- **`rst` mid-operation:**
  - In the next cycle: `lcd_e`=0, `wr_ready`=0, `init_done`=0.
  - The full sequence restarts from PWR after release.
- A stale high flag at state entry never causes an early exit, because of the first-cycle ignore rule.

## Configuration
- `LCD_TWO_LINE_EN`:
  - Defined: init step 3 writes 0x38 (8-bit, 2-line, 5x8 font).
  - Undefined: step 3 writes 0x30 (8-bit, 1-line, 5x8).
  - No other behaviour changes.

## Test plan
- **Power-on:** release `rst` → `lcd_e` stays 0 for ≥720000 cycles; first E pulse carries `lcd_data`=0x30, `lcd_rs`=0; `flag_rst` pulses on entry to PWR.
- **Init sequence:** run to completion → E pulses carry 0x30, 0x30, 0x30, 0x38 (macro on), 0x0C, 0x01, 0x06. Gaps from E fall to next E rise are ≥196800, 4800, 4800, 2016, 2016, 78720 cycles. `init_done` rises ≥2016 cycles after the last E fall.
- **Data write:** `wr_valid`=1, `wr_rs`=1, `wr_data`=0x41 in IDLE → exactly one E pulse with `lcd_rs`=1, `lcd_data`=0x41, E high ≥14 cycles; `wr_ready` returns ≥2016 cycles after E fall.
- **Clear command:** `wr_rs`=0, `wr_data`=0x01 → `wr_ready` low ≥78720 cycles after E fall. Repeat with 0x80 → only ≥2016 cycles.
- **Early request:** `wr_valid` held high during init → no client byte on the bus until `init_done`=1, then accepted exactly once.
- **Reset mid-pulse:** assert `rst` during EHI → `lcd_e`=0 the next cycle; after release, the ≥720000-cycle wait is followed again by 0x30.
